mips_cpu_bus: RTL and testbench

- Multicycle 32-bit MIPS-I subset CPU with a single Avalon-MM master port for both instruction fetch and data access.
- Sits at the top of the CPU hierarchy. Its bus connects to a word-wide memory slave (RAM_avalon in simulation).
- Runs from the reset vector until it jumps to address 0, then halts and drops `active`.
- Exposes `register_v0` ($2) for checking results.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mips_regfile.sv | 27 ++
 rtl/mips_cpu_bus.sv | 155 +++++++++++++++
 tb/tb_mips_cpu_bus.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, function codes, FSM states and reset vector shared by the MIPS bus CPU.
package mips_pkg;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_e;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 GPR file with two combinational reads, one synchronous write, $0 fixed at zero.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] v0
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  always_comb begin
    regs_d = regs_q;
    if (we && wa != 5'd0) regs_d[wa] = wd;
  end
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: 32'h0};
    else regs_q <= regs_d;
  end
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
  assign v0 = regs_q[2];
endmodule

// File: rtl/mips_cpu_bus.sv
// mips_cpu_bus: multicycle MIPS-I subset CPU sharing one Avalon-MM master for fetch and data.
module mips_cpu_bus
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sh, wa, wb_addr;
  logic [31:0] rs_v, rt_v, simm, zimm, res, tgt, mem_addr, wd;
  logic wb, taken, is_lw, is_mem, we, retire;

  assign {op, rs, rt, rd, sh, fn} = ir_q;
  assign simm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm = {16'h0, ir_q[15:0]};
  assign is_lw = op == OP_LW;
  assign is_mem = is_lw || op == OP_SW;
  assign mem_addr = rs_v + simm;
  assign writedata = rt_v;
  assign byteenable = 4'hF;
  assign active = state_q != S_HALTED;

  mips_regfile u_rf (
    .clk(clk), .reset(reset), .ra1(rs), .ra2(rt), .we(we), .wa(wa), .wd(wd),
    .rd1(rs_v), .rd2(rt_v), .v0(register_v0)
  );

  always_comb begin
    res = '0;
    wb = 1'b0;
    wb_addr = rt;
    taken = 1'b0;
    tgt = rs_v;
    case (op)
      OP_RTYPE: begin
        wb = 1'b1;
        wb_addr = rd;
        case (fn)
          FN_SLL:  res = rt_v << sh;
          FN_SRL:  res = rt_v >> sh;
          FN_SRA:  res = $signed(rt_v) >>> sh;
          FN_SLLV: res = rt_v << rs_v[4:0];
          FN_SRLV: res = rt_v >> rs_v[4:0];
          FN_SRAV: res = $signed(rt_v) >>> rs_v[4:0];
          FN_JR:   begin wb = 1'b0; taken = 1'b1; end
          FN_JALR: begin taken = 1'b1; res = pc_q + 32'd8; end
          FN_ADDU: res = rs_v + rt_v;
          FN_SUBU: res = rs_v - rt_v;
          FN_AND:  res = rs_v & rt_v;
          FN_OR:   res = rs_v | rt_v;
          FN_XOR:  res = rs_v ^ rt_v;
          FN_NOR:  res = ~(rs_v | rt_v);
          FN_SLT:  res = {31'b0, $signed(rs_v) < $signed(rt_v)};
          FN_SLTU: res = {31'b0, rs_v < rt_v};
          default: wb = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        taken = 1'b1;
        tgt = {npc_q[31:28], ir_q[25:0], 2'b00};
        wb = op == OP_JAL;
        wb_addr = 5'd31;
        res = pc_q + 32'd8;
      end
      // Branch offsets are relative to the delay-slot address, which is npc_q.
      OP_BEQ, OP_BNE: begin
        taken = (rs_v == rt_v) ^ (op == OP_BNE);
        tgt = npc_q + {simm[29:0], 2'b00};
      end
      OP_ADDIU: begin wb = 1'b1; res = rs_v + simm; end
      OP_SLTI:  begin wb = 1'b1; res = {31'b0, $signed(rs_v) < $signed(simm)}; end
      OP_SLTIU: begin wb = 1'b1; res = {31'b0, rs_v < simm}; end
      OP_ANDI:  begin wb = 1'b1; res = rs_v & zimm; end
      OP_ORI:   begin wb = 1'b1; res = rs_v | zimm; end
      OP_XORI:  begin wb = 1'b1; res = rs_v ^ zimm; end
      OP_LUI:   begin wb = 1'b1; res = {ir_q[15:0], 16'h0}; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    npc_d = npc_q;
    ir_d = ir_q;
    read = 1'b0;
    write = 1'b0;
    address = pc_q & ~32'd3;
    we = 1'b0;
    wa = wb_addr;
    wd = res;
    retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        read = 1'b1;
        if (!waitrequest) begin
          ir_d = readdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_MEM;
        retire = !is_mem;
        we = wb && !is_mem;
      end
      S_MEM: begin
        address = mem_addr & ~32'd3;
        read = is_lw;
        write = !is_lw;
        retire = !waitrequest;
        we = is_lw && !waitrequest;
        wa = rt;
        wd = readdata;
      end
      default: ;
    endcase
    // Retiring with a zero next-PC means the jump-to-0 delay slot just finished.
    if (retire) begin
      pc_d = npc_q;
      npc_d = taken ? tgt : npc_q + 32'd4;
      state_d = npc_q == 32'd0 ? S_HALTED : S_FETCH;
    end
    if (reset) begin
      read = 1'b0;
      write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q <= RESET_VECTOR;
      npc_q <= RESET_VECTOR + 32'd4;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      npc_q <= npc_d;
      ir_q <= ir_d;
    end
  end
endmodule

// File: tb/tb_mips_cpu_bus.sv
// tb_mips_cpu_bus: directed and random programs checked against an instruction-level model.
module tb_mips_cpu_bus;
  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] JR0 = 32'h00000008;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata;
  logic [31:0] readdata = 32'h0;
  logic [3:0] byteenable;
  logic [31:0] prog [64];
  logic [31:0] dmem [64];
  logic [31:0] m_dmem [64];
  int n_cmp = 0, n_bad = 0, stall_cfg = 0, stall_cnt = 0, emit_idx = 0;
  logic prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0, saw_write = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0, seen_wdata = 32'h0;
  logic [3:0] seen_be = 4'h0;

  mips_cpu_bus dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  assign waitrequest = (read || write) && stall_cnt < stall_cfg;

  always @(negedge clk)
    readdata = address[31:8] == RV[31:8] ? prog[address[7:2]] :
               address[31:8] == 24'h000010 ? dmem[address[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (reset || !(read || write)) stall_cnt <= 0;
    else if (!waitrequest) begin
      stall_cnt <= 0;
      if (write && address[31:8] == 24'h000010) dmem[address[7:2]] = writedata;
    end else stall_cnt <= stall_cnt + 1;
  end

  always @(negedge clk) begin
    if (prev_stall && !reset) begin
      check("stall_addr", address, prev_addr);
      check("stall_req", {30'b0, read, write}, {30'b0, prev_rd, prev_wr});
      check("stall_wdata", writedata, prev_wdata);
    end
    prev_stall = (read || write) && waitrequest && !reset;
    prev_addr = address;
    prev_rd = read;
    prev_wr = write;
    prev_wdata = writedata;
    if (write && !waitrequest) begin
      saw_write = 1'b1;
      seen_be = byteenable;
      seen_wdata = writedata;
    end
  end

  function automatic logic [31:0] ii(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] ri(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic int rr();
    return int'($urandom_range(0, 7));
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      prog[i] = NOP;
      dmem[i] = $urandom;
    end
    emit_idx = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    prog[emit_idx] = w;
    emit_idx++;
  endtask

  // Executes the loaded program one instruction at a time with architectural delay-slot semantics.
  task automatic model_run(output logic [31:0] v0, output int na, output int nm);
    logic [31:0] r [32];
    logic [31:0] pc, npc, nx, ins, s, t, se, res, ea;
    int op, fn, rd, sh, wa, steps;
    bit wr;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    for (int i = 0; i < 64; i++) m_dmem[i] = dmem[i];
    pc = RV; npc = RV + 4; na = 0; nm = 0; steps = 0;
    while (pc != 0 && steps < 1000) begin
      ins = pc[31:8] == RV[31:8] ? prog[pc[7:2]] : 32'h0;
      op = int'(ins[31:26]); fn = int'(ins[5:0]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
      s = r[ins[25:21]]; t = r[ins[20:16]];
      se = {{16{ins[15]}}, ins[15:0]};
      ea = s + se;
      nx = npc + 4; wr = 1; wa = int'(ins[20:16]); res = 32'h0;
      case (op)
        0: begin
          wa = rd;
          case (fn)
            0: res = t << sh;
            2: res = t >> sh;
            3: res = $signed(t) >>> sh;
            4: res = t << s[4:0];
            6: res = t >> s[4:0];
            7: res = $signed(t) >>> s[4:0];
            8: begin wr = 0; nx = s; end
            9: begin nx = s; res = pc + 8; end
            33: res = s + t;
            35: res = s - t;
            36: res = s & t;
            37: res = s | t;
            38: res = s ^ t;
            39: res = ~(s | t);
            42: res = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
            43: res = (s < t) ? 32'd1 : 32'd0;
            default: wr = 0;
          endcase
        end
        2: begin wr = 0; nx = {npc[31:28], ins[25:0], 2'b00}; end
        3: begin wa = 31; res = pc + 8; nx = {npc[31:28], ins[25:0], 2'b00}; end
        4: begin wr = 0; if (s == t) nx = npc + (se << 2); end
        5: begin wr = 0; if (s != t) nx = npc + (se << 2); end
        9: res = s + se;
        10: res = ($signed(s) < $signed(se)) ? 32'd1 : 32'd0;
        11: res = (s < se) ? 32'd1 : 32'd0;
        12: res = s & {16'h0, ins[15:0]};
        13: res = s | {16'h0, ins[15:0]};
        14: res = s ^ {16'h0, ins[15:0]};
        15: res = {ins[15:0], 16'h0};
        35: res = ea[31:8] == 24'h000010 ? m_dmem[ea[7:2]] : 32'h0;
        43: begin wr = 0; if (ea[31:8] == 24'h000010) m_dmem[ea[7:2]] = t; end
        default: wr = 0;
      endcase
      if (op == 35 || op == 43) nm++; else na++;
      if (wr && wa != 0) r[wa] = res;
      pc = npc; npc = nx; steps++;
    end
    v0 = r[2];
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    saw_write = 1'b0;
    @(negedge clk);
    check("rst_read", 32'(read), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (active && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    check("halted", 32'(active), 32'd0);
  endtask

  task automatic run_check(input string tag, input int stall, output logic [31:0] v0);
    logic [31:0] mv0;
    int na, nm, cyc;
    stall_cfg = stall;
    model_run(mv0, na, nm);
    pulse_reset();
    check({tag, "_v0_rst"}, register_v0, 32'h0);
    check({tag, "_active"}, 32'(active), 32'd1);
    check({tag, "_fetch_rd"}, 32'(read), 32'd1);
    check({tag, "_fetch_addr"}, address, RV);
    wait_halt(cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'(na * (2 + stall) + nm * (3 + 2 * stall)));
    check({tag, "_v0_model"}, register_v0, mv0);
    repeat (2) @(negedge clk);
    check({tag, "_halt_bus"}, {30'b0, read, write, active}, 32'h0);
    v0 = register_v0;
  endtask

  task automatic gen_random();
    int iops [7] = '{9, 10, 11, 12, 13, 14, 15};
    int rfns [14] = '{0, 2, 3, 4, 6, 7, 33, 35, 36, 37, 38, 39, 42, 43};
    int n;
    clear_mem();
    n = int'($urandom_range(6, 14));
    for (int i = 0; i < n; i++)
      case ($urandom_range(0, 5))
        0, 1: emit(ii(iops[$urandom_range(0, 6)], rr(), rr(), int'($urandom)));
        2, 3: emit(ri(rr(), rr(), rr(), int'($urandom_range(0, 31)), rfns[$urandom_range(0, 13)]));
        4: emit(ii($urandom_range(0, 1) ? 35 : 43, 0, rr(), 'h1000 + 4 * int'($urandom_range(0, 15))));
        default: emit(ii(int'($urandom_range(4, 5)), rr(), rr(), 1));
      endcase
    for (int r = 1; r < 8; r++) if (r != 2) emit(ri(2, r, 2, 0, 38));
    emit(JR0);
    emit(NOP);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] jt;
    int cyc;
    clear_mem();
    emit(ii(9, 0, 2, 5)); emit(JR0); emit(NOP);
    run_check("basic", 0, v);
    check("basic_v0", v, 32'd5);

    clear_mem();
    emit(ii(15, 0, 2, 'h1234)); emit(ii(13, 2, 2, 'h5678)); emit(JR0); emit(NOP);
    run_check("lui_ori", 0, v);
    check("lui_ori_v0", v, 32'h12345678);

    clear_mem();
    emit(ii(15, 0, 4, 'hDEAD)); emit(ii(13, 4, 4, 'hBEEF));
    emit(ii(43, 0, 4, 'h1000)); emit(ii(35, 0, 2, 'h1000)); emit(JR0); emit(NOP);
    run_check("ldst", 1, v);
    check("ldst_v0", v, 32'hDEADBEEF);
    check("ldst_wr_seen", 32'(saw_write), 32'd1);
    check("ldst_be", 32'(seen_be), 32'hF);
    check("ldst_wdata", seen_wdata, 32'hDEADBEEF);

    clear_mem();
    emit(ii(4, 0, 0, 2)); emit(ii(9, 0, 2, 1)); emit(ii(9, 2, 2, 10));
    emit(ii(9, 2, 2, 100)); emit(JR0); emit(NOP);
    run_check("branch", 0, v);
    check("branch_v0", v, 32'd101);

    clear_mem();
    jt = (RV + 32'd12) >> 2;
    emit({6'd3, jt[25:0]}); emit(NOP); emit(ii(9, 0, 2, 7));
    emit(ri(31, 0, 2, 0, 33)); emit(JR0); emit(NOP);
    run_check("jal", 0, v);
    check("jal_v0", v, RV + 32'd8);

    clear_mem();
    emit(ii(9, 0, 2, 5)); emit(JR0); emit(NOP);
    run_check("stall", 3, v);
    check("stall_v0", v, 32'd5);

    clear_mem();
    emit(ii(9, 0, 3, 'hFFFF)); emit(ri(3, 0, 2, 0, 42)); emit(JR0); emit(NOP);
    run_check("slt", 0, v);
    check("slt_v0", v, 32'd1);

    stall_cfg = 3;
    pulse_reset();
    repeat (2) @(negedge clk);
    check("mid_fetch_rd", 32'(read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rd", 32'(read), 32'd0);
    reset = 1'b0;
    #1;
    check("restart_rd", 32'(read), 32'd1);
    check("restart_addr", address, RV);
    wait_halt(cyc);
    check("restart_v0", register_v0, 32'd1);

    repeat (20) begin
      gen_random();
      run_check("rnd", int'($urandom_range(0, 2)), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
